// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe: operand beat in, result beat plus status flags out.
interface alu_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic             err;

  modport master (
    output in_valid, A, B, opcode, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, err
  );

  modport slave (
    input  in_valid, A, B, opcode, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, err
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes: single-cycle ALU ops, shifts/rotates, compares,
// and an iterative shift-add multiplier (MUL/MULH) sequenced by an IDLE/MUL/DONE FSM.
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input logic        clk,
  input logic        rst_n,
  alu_pipe_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic               out_valid_r;
  logic [WIDTH-1:0]   result_r;
  logic               z_r, n_r, c_r, v_r, err_r;
  logic [WIDTH-1:0]   mul_a_r, mul_b_r;
  logic               mul_high_r;
  logic [2*WIDTH-1:0] prod_r;
  logic [CW-1:0]      cnt_r;

  logic               in_ready_s, accept_s, is_mul_s;
  logic [WIDTH-1:0]   alu_res_s, ld_res_s, mul_res_s;
  logic               alu_c_s, alu_v_s, alu_err_s, ld_c_s, ld_v_s, ld_err_s, mul_c_s;
  logic [SHW-1:0]     sh_s;
  logic [WIDTH:0]     sum_s, diff_s, mul_sum_s;
  logic [2*WIDTH-1:0] shl_s, shr_s, rol_s, ror_s;
  logic signed [2*WIDTH-1:0] sra_s;

  assign in_ready_s = (state_r == S_IDLE) && (!out_valid_r || bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;
  assign is_mul_s   = (bus.opcode[3:1] == 3'b110);

  // Single-cycle datapath; shifts use a double-width window so the last bit out lands at a fixed position.
  always_comb begin
    sh_s      = bus.B[SHW-1:0];
    sum_s     = {1'b0, bus.A} + {1'b0, bus.B};
    diff_s    = {1'b0, bus.A} - {1'b0, bus.B};
    shl_s     = {{WIDTH{1'b0}}, bus.A} << sh_s;
    shr_s     = {bus.A, {WIDTH{1'b0}}} >> sh_s;
    sra_s     = $signed({bus.A, {WIDTH{1'b0}}}) >>> sh_s;
    rol_s     = {bus.A, bus.A} << sh_s;
    ror_s     = {bus.A, bus.A} >> sh_s;
    alu_res_s = {WIDTH{1'b0}};
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    alu_err_s = 1'b0;
    case (bus.opcode)
      4'b0000: begin
        alu_res_s = sum_s[WIDTH-1:0];
        alu_c_s   = sum_s[WIDTH];
        alu_v_s   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum_s[WIDTH-1] != bus.A[WIDTH-1]);
      end
      4'b0001: begin
        alu_res_s = diff_s[WIDTH-1:0];
        alu_c_s   = diff_s[WIDTH];
        alu_v_s   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff_s[WIDTH-1] != bus.A[WIDTH-1]);
      end
      4'b0010: alu_res_s = bus.A & bus.B;
      4'b0011: alu_res_s = bus.A | bus.B;
      4'b0100: alu_res_s = bus.A ^ bus.B;
      4'b0101: begin
        alu_res_s = shl_s[WIDTH-1:0];
        alu_c_s   = shl_s[WIDTH];
      end
      4'b0110: begin
        alu_res_s = shr_s[2*WIDTH-1:WIDTH];
        alu_c_s   = shr_s[WIDTH-1];
      end
      4'b0111: begin
        alu_res_s = sra_s[2*WIDTH-1:WIDTH];
        alu_c_s   = sra_s[WIDTH-1];
      end
      4'b1000: alu_res_s = rol_s[2*WIDTH-1:WIDTH];
      4'b1001: alu_res_s = ror_s[WIDTH-1:0];
      4'b1010: alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      4'b1011: alu_res_s = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      4'b1100, 4'b1101: alu_res_s = {WIDTH{1'b0}};
      default: alu_err_s = 1'b1;
    endcase
  end

  // Multiplier step and final selection; prod_r low half doubles as the shift-out of partial sums.
  always_comb begin
    mul_sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, (mul_b_r[0] ? mul_a_r : {WIDTH{1'b0}})};
    mul_res_s = mul_high_r ? prod_r[2*WIDTH-1:WIDTH] : prod_r[WIDTH-1:0];
    mul_c_s   = !mul_high_r && (prod_r[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
    if (state_r == S_DONE) begin
      ld_res_s = mul_res_s;
      ld_c_s   = mul_c_s;
      ld_v_s   = 1'b0;
      ld_err_s = 1'b0;
    end else begin
      ld_res_s = alu_res_s;
      ld_c_s   = alu_c_s;
      ld_v_s   = alu_v_s;
      ld_err_s = alu_err_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s && is_mul_s) state_s = S_MUL;
        else                      state_s = S_IDLE;
      end
      S_MUL: begin
        if (cnt_r == {{(CW-1){1'b0}}, 1'b1}) state_s = S_DONE;
        else                                 state_s = S_MUL;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_s;
  end

  // Multiplier operand latch, product accumulator and step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a_r    <= {WIDTH{1'b0}};
      mul_b_r    <= {WIDTH{1'b0}};
      mul_high_r <= 1'b0;
      prod_r     <= {(2*WIDTH){1'b0}};
      cnt_r      <= {CW{1'b0}};
    end else if (accept_s && is_mul_s) begin
      mul_a_r    <= bus.A;
      mul_b_r    <= bus.B;
      mul_high_r <= bus.opcode[0];
      prod_r     <= {(2*WIDTH){1'b0}};
      cnt_r      <= CW'(WIDTH);
    end else if (state_r == S_MUL) begin
      prod_r  <= {mul_sum_s, prod_r[WIDTH-1:1]};
      mul_b_r <= {1'b0, mul_b_r[WIDTH-1:1]};
      cnt_r   <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Result/flag register: loads on a single-cycle accept or multiplier completion, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      z_r         <= 1'b0;
      n_r         <= 1'b0;
      c_r         <= 1'b0;
      v_r         <= 1'b0;
      err_r       <= 1'b0;
    end else if ((state_r == S_DONE) || (accept_s && !is_mul_s)) begin
      out_valid_r <= 1'b1;
      result_r    <= ld_res_s;
      z_r         <= (ld_res_s == {WIDTH{1'b0}});
      n_r         <= ld_res_s[WIDTH-1];
      c_r         <= ld_c_s;
      v_r         <= ld_v_s;
      err_r       <= ld_err_s;
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.flag_z    = z_r;
  assign bus.flag_n    = n_r;
  assign bus.flag_c    = c_r;
  assign bus.flag_v    = v_r;
  assign bus.err       = err_r;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=16) with hand-computed expected values.
module tb_alu_pipe;
  localparam int W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W)) bus ();
  alu_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {err, z, n, c, v}
  function automatic logic [4:0] flags();
    return {bus.err, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v};
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] er, input logic [4:0] ef,
                        input int el);
    int   n;
    logic busy_ok;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.A         = a;
    bus.B         = b;
    bus.opcode    = op;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.A        = 16'hDEAD;
    bus.B        = 16'hBEEF;
    bus.opcode   = 4'b0000;
    n       = 1;
    busy_ok = 1'b1;
    while (!bus.out_valid && n < 60) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(posedge clk); #1; n++;
    end
    check({tag, ".lat"}, 32'(n), 32'(el));
    if (el > 1) check({tag, ".busy"}, 32'(busy_ok), 32'd1);
    check({tag, ".res"}, 32'(bus.result), 32'(er));
    check({tag, ".flags"}, 32'(flags()), 32'(ef));
  endtask

  initial begin
    bit seen;
    bus.in_valid  = 1'b0;
    bus.A         = 16'h0000;
    bus.B         = 16'h0000;
    bus.opcode    = 4'b0000;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out", {15'd0, bus.out_valid, bus.result}, 32'd0);
    check("rst.flags", 32'(flags()), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic ops, back-to-back, A=5 B=3
    run_op("add",  4'b0000, 16'h0005, 16'h0003, 16'h0008, 5'b00000, 1);
    run_op("sub",  4'b0001, 16'h0005, 16'h0003, 16'h0002, 5'b00000, 1);
    run_op("and",  4'b0010, 16'h0005, 16'h0003, 16'h0001, 5'b00000, 1);
    run_op("or",   4'b0011, 16'h0005, 16'h0003, 16'h0007, 5'b00000, 1);
    run_op("xor",  4'b0100, 16'h0005, 16'h0003, 16'h0006, 5'b00000, 1);
    run_op("shl",  4'b0101, 16'h0005, 16'h0003, 16'h0028, 5'b00000, 1);
    run_op("shr",  4'b0110, 16'h0005, 16'h0003, 16'h0000, 5'b01010, 1);

    run_op("sub_neg",  4'b0001, 16'h0003, 16'h0005, 16'hFFFE, 5'b00110, 1);
    run_op("add_ovf",  4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 5'b00101, 1);
    run_op("add_wrap", 4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 5'b01010, 1);

    run_op("shl_c",  4'b0101, 16'h8001, 16'h0001, 16'h0002, 5'b00010, 1);
    run_op("sra",    4'b0111, 16'h8000, 16'h0004, 16'hF800, 5'b00100, 1);
    run_op("ror",    4'b1001, 16'h0001, 16'h0001, 16'h8000, 5'b00100, 1);
    run_op("rol",    4'b1000, 16'h8001, 16'h0004, 16'h0018, 5'b00000, 1);
    run_op("slt",    4'b1010, 16'hFFFF, 16'h0001, 16'h0001, 5'b00000, 1);
    run_op("sltu",   4'b1011, 16'hFFFF, 16'h0001, 16'h0000, 5'b01000, 1);
    run_op("shr_sh0", 4'b0110, 16'h00F0, 16'h0010, 16'h00F0, 5'b00000, 1);

    run_op("mul",     4'b1100, 16'h0100, 16'h0100, 16'h0000, 5'b01010, 18);
    run_op("mulh",    4'b1101, 16'h0100, 16'h0100, 16'h0001, 5'b00000, 18);
    run_op("mul_ff",  4'b1100, 16'hFFFF, 16'hFFFF, 16'h0001, 5'b00010, 18);
    run_op("mulh_ff", 4'b1101, 16'hFFFF, 16'hFFFF, 16'hFFFE, 5'b00100, 18);

    // Backpressure
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.A         = 16'h0010;
    bus.B         = 16'h0020;
    bus.opcode    = 4'b0000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp.valid", 32'(bus.out_valid), 32'd1);
    check("bp.in_ready", 32'(bus.in_ready), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("bp.hold_res", 32'(bus.result), 32'h0030);
    check("bp.hold_valid", 32'(bus.out_valid), 32'd1);
    check("bp.hold_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.A         = 16'h00FF;
    bus.B         = 16'h0F0F;
    bus.opcode    = 4'b0100;
    #1;
    check("bp.swap_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp.swap_valid", 32'(bus.out_valid), 32'd1);
    check("bp.swap_res", 32'(bus.result), 32'h0FF0);
    @(posedge clk); #1;
    check("bp.drain", 32'(bus.out_valid), 32'd0);

    run_op("ill_e", 4'b1110, 16'h1234, 16'h5678, 16'h0000, 5'b11000, 1);
    run_op("ill_f", 4'b1111, 16'h1234, 16'h5678, 16'h0000, 5'b11000, 1);

    // Reset during a multiply
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.A        = 16'h0003;
    bus.B        = 16'h0005;
    bus.opcode   = 4'b1100;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("rmul.busy", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rmul.out", {15'd0, bus.out_valid, bus.result}, 32'd0);
    check("rmul.flags", 32'(flags()), 32'd0);
    check("rmul.idle", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("rmul.nores", 32'(seen), 32'd0);
    run_op("post_rst_add", 4'b0000, 16'h0001, 16'h0002, 16'h0003, 5'b00000, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
